// File: rtl/mcu_pkg.sv
// Shared types and constants for the CPU/MCU shared-RAM arbiter.
package mcu_pkg;

  // CPU transaction sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StWait,
    StAck
  } arb_state_e;

  // Default mailbox byte addresses
  localparam logic [11:0] MboxToMcuDefault = 12'hFFF;
  localparam logic [11:0] MboxToCpuDefault = 12'hFFE;

  // MCU access latched the cycle after its strobe
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
  } mcu_req_t;

  // Select one byte lane of a 16-bit word (lane 0 = low byte)
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

  // Replace one byte lane of a 16-bit word
  function automatic logic [15:0] lane_merge(input logic [15:0] word, input logic lane,
                                             input logic [7:0] b);
    return lane ? {b, word[7:0]} : {word[15:8], b};
  endfunction

endpackage

// File: rtl/mcu_mailbox.sv
// Mailbox interrupt flags between CPU and MCU, decoded from the shared RAM port.
module mcu_mailbox
  import mcu_pkg::*;
#(
  parameter logic [11:0] MBOX_TO_MCU = MboxToMcuDefault,
  parameter logic [11:0] MBOX_TO_CPU = MboxToCpuDefault
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [11:0] i_addr,
  input  logic        i_cpu_wr,
  input  logic        i_mcu_wr,
  input  logic        i_mcu_rd,
  input  logic        i_cpu_int_clr,
  output logic        o_mcu_int,
  output logic        o_cpu_int
);

  logic r_mcu_int;
  logic r_cpu_int;
  logic w_mcu_set;
  logic w_mcu_clr;
  logic w_cpu_set;

  assign w_mcu_set = i_cpu_wr & (i_addr == MBOX_TO_MCU);
  assign w_mcu_clr = i_mcu_rd & (i_addr == MBOX_TO_MCU);
  assign w_cpu_set = i_mcu_wr & (i_addr == MBOX_TO_CPU);

  // Interrupt flags; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcu_int <= 1'b0;
      r_cpu_int <= 1'b0;
    end else begin
      if (w_mcu_set) begin
        r_mcu_int <= 1'b1;
      end else if (w_mcu_clr) begin
        r_mcu_int <= 1'b0;
      end
      if (w_cpu_set) begin
        r_cpu_int <= 1'b1;
      end else if (i_cpu_int_clr) begin
        r_cpu_int <= 1'b0;
      end
    end
  end

  assign o_mcu_int = r_mcu_int;
  assign o_cpu_int = r_cpu_int;

endmodule

// File: rtl/mcu_shared_ram_arb.sv
// Shared 4 KB byte RAM arbiter: MCU accesses have fixed priority, CPU word accesses
// are split into byte slots, and mailbox interrupts are raised on both sides.
module mcu_shared_ram_arb
  import mcu_pkg::*;
#(
  parameter logic [11:0] MBOX_TO_MCU = MboxToMcuDefault,
  parameter logic [11:0] MBOX_TO_CPU = MboxToCpuDefault
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [10:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  input  logic        mcu_cs,
  input  logic        mcu_we,
  input  logic [11:0] mcu_addr,
  input  logic [7:0]  mcu_din,
  output logic [7:0]  mcu_dout,
  output logic        mcu_int,
  output logic        cpu_int,
  input  logic        cpu_int_clr,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_q
);

  arb_state_e  r_state;
  logic [10:0] r_addr;
  logic        r_we;
  logic        r_be_hi;
  logic [15:0] r_din;
  logic [15:0] r_rd_buf;
  logic [15:0] r_cpu_dout;
  logic        r_cpu_ack;
  logic        r_cpu_rd_pend;
  logic        r_cpu_rd_lane;
  mcu_req_t    r_mcu;
  logic        r_mcu_rd_pend;
  logic [7:0]  r_mcu_dout;

  logic        w_mcu_go;
  logic        w_cpu_want;
  logic        w_cpu_go;
  logic        w_cpu_lane;
  logic        w_cpu_wr;
  logic        w_mcu_wr;
  logic        w_mcu_rd;
  logic [15:0] w_rd_word;

  // RAM port arbitration; reset gates the port so an interrupted write never lands
  always_comb begin
    w_mcu_go   = r_mcu.valid & ~reset;
    w_cpu_want = 1'b0;
    w_cpu_lane = 1'b0;
    case (r_state)
      StLo: w_cpu_want = 1'b1;
      StHi: begin
        w_cpu_want = 1'b1;
        w_cpu_lane = 1'b1;
      end
      default: ;
    endcase
    w_cpu_go  = w_cpu_want & ~w_mcu_go & ~reset;
    ram_addr  = 12'h000;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (w_mcu_go) begin
      ram_addr  = r_mcu.addr;
      ram_we    = r_mcu.we;
      ram_wdata = r_mcu.we ? r_mcu.data : 8'h00;
    end else if (w_cpu_go) begin
      ram_addr  = {r_addr, w_cpu_lane};
      ram_we    = r_we;
      ram_wdata = r_we ? lane_byte(r_din, w_cpu_lane) : 8'h00;
    end
  end

  // Read buffer with the byte returning this cycle folded in
  assign w_rd_word = r_cpu_rd_pend ? lane_merge(r_rd_buf, r_cpu_rd_lane, ram_q) : r_rd_buf;

  // CPU sequencer: byte slots per enabled lane, blocked slots hold, skipped lanes cost nothing
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      r_state       <= StIdle;
      r_addr        <= 11'h000;
      r_we          <= 1'b0;
      r_be_hi       <= 1'b0;
      r_din         <= 16'h0000;
      r_rd_buf      <= 16'h0000;
      r_cpu_dout    <= 16'h0000;
      r_cpu_ack     <= 1'b0;
      r_cpu_rd_pend <= 1'b0;
      r_cpu_rd_lane <= 1'b0;
    end else begin
      r_cpu_ack     <= 1'b0;
      r_cpu_rd_pend <= w_cpu_go & ~r_we;
      r_cpu_rd_lane <= w_cpu_lane;
      if (r_cpu_rd_pend) begin
        r_rd_buf <= w_rd_word;
      end
      case (r_state)
        StIdle: begin
          if (cpu_req) begin
            r_addr   <= cpu_addr;
            r_we     <= cpu_we;
            r_be_hi  <= cpu_be[1];
            r_din    <= cpu_din;
            r_rd_buf <= 16'h0000;
            if (cpu_be[0]) begin
              r_state <= StLo;
            end else if (cpu_be[1]) begin
              r_state <= StHi;
            end else begin
              r_state   <= StAck;
              r_cpu_ack <= 1'b1;
              if (!cpu_we) begin
                r_cpu_dout <= 16'h0000;
              end
            end
          end
        end
        StLo: begin
          if (w_cpu_go) begin
            if (r_be_hi) begin
              r_state <= StHi;
            end else if (r_we) begin
              r_state   <= StAck;
              r_cpu_ack <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StHi: begin
          if (w_cpu_go) begin
            if (r_we) begin
              r_state   <= StAck;
              r_cpu_ack <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          r_cpu_dout <= w_rd_word;
          r_state    <= StAck;
          r_cpu_ack  <= 1'b1;
        end
        StAck: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // MCU strobe capture and read-data return
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      r_mcu         <= '0;
      r_mcu_rd_pend <= 1'b0;
      r_mcu_dout    <= 8'h00;
    end else begin
      r_mcu.valid <= mcu_cs;
      if (mcu_cs) begin
        r_mcu.we   <= mcu_we;
        r_mcu.addr <= mcu_addr;
        r_mcu.data <= mcu_din;
      end
      r_mcu_rd_pend <= w_mcu_go & ~r_mcu.we;
      if (r_mcu_rd_pend) begin
        r_mcu_dout <= ram_q;
      end
    end
  end

  assign w_cpu_wr = w_cpu_go & r_we;
  assign w_mcu_wr = w_mcu_go & r_mcu.we;
  assign w_mcu_rd = w_mcu_go & ~r_mcu.we;

  mcu_mailbox #(
    .MBOX_TO_MCU(MBOX_TO_MCU),
    .MBOX_TO_CPU(MBOX_TO_CPU)
  ) u_mailbox (
    .i_clk        (CLK_32M),
    .i_reset      (reset),
    .i_addr       (ram_addr),
    .i_cpu_wr     (w_cpu_wr),
    .i_mcu_wr     (w_mcu_wr),
    .i_mcu_rd     (w_mcu_rd),
    .i_cpu_int_clr(cpu_int_clr),
    .o_mcu_int    (mcu_int),
    .o_cpu_int    (cpu_int)
  );

  assign cpu_dout = r_cpu_dout;
  assign cpu_ack  = r_cpu_ack;
  assign mcu_dout = r_mcu_dout;

endmodule

// File: tb/tb_mcu_shared_ram_arb.sv
// Directed bench for mcu_shared_ram_arb with a behavioural synchronous RAM.
module tb_mcu_shared_ram_arb;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic        mcu_cs;
  logic        mcu_we;
  logic [11:0] mcu_addr;
  logic [7:0]  mcu_din;
  logic [7:0]  mcu_dout;
  logic        mcu_int;
  logic        cpu_int;
  logic        cpu_int_clr;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q;

  logic [7:0]  mem [4096];
  logic        mem_clr;
  int          n_we;
  int          n_acc;
  int          n_checks;
  int          n_errors;
  logic [7:0]  mcu_prev;
  logic        soak_done;

  mcu_shared_ram_arb dut (
    .CLK_32M    (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_ack    (cpu_ack),
    .mcu_cs     (mcu_cs),
    .mcu_we     (mcu_we),
    .mcu_addr   (mcu_addr),
    .mcu_din    (mcu_din),
    .mcu_dout   (mcu_dout),
    .mcu_int    (mcu_int),
    .cpu_int    (cpu_int),
    .cpu_int_clr(cpu_int_clr),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_q      (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write; contents survive DUT reset
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  // Port activity counters (only this block writes them)
  initial begin
    n_we  = 0;
    n_acc = 0;
  end
  always @(posedge clk) begin
    if (ram_we) n_we++;
    if (ram_addr != 12'h000) n_acc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU transaction; lat = cycles from the accepting edge to ack (-1 on timeout)
  task automatic cpu_txn(input logic [10:0] a, input logic we, input logic [1:0] be,
                         input logic [15:0] d, output int lat, output logic [15:0] q);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    cpu_we   = we;
    cpu_be   = be;
    cpu_din  = d;
    lat = -1;
    q   = 16'h0000;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        lat = k;
        q   = cpu_dout;
        break;
      end
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // MCU read: data must appear exactly three cycles after the strobe cycle
  task automatic mcu_rd(input logic [11:0] a, input logic [7:0] exp);
    @(negedge clk);
    mcu_cs   = 1'b1;
    mcu_we   = 1'b0;
    mcu_addr = a;
    @(posedge clk); #1;
    mcu_cs = 1'b0;
    @(posedge clk); #1;
    check("mcu_dout_hold", {24'h0, mcu_dout}, {24'h0, mcu_prev});
    @(posedge clk); #1;
    check("mcu_dout_n3", {24'h0, mcu_dout}, {24'h0, exp});
    mcu_prev = exp;
  endtask

  // MCU write; optionally pulse cpu_int_clr in the cycle the write reaches RAM
  task automatic mcu_wr(input logic [11:0] a, input logic [7:0] d, input logic clr_same);
    @(negedge clk);
    mcu_cs   = 1'b1;
    mcu_we   = 1'b1;
    mcu_addr = a;
    mcu_din  = d;
    @(posedge clk); #1;
    mcu_cs      = 1'b0;
    cpu_int_clr = clr_same;
    @(posedge clk); #1;
    cpu_int_clr = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [15:0] q;
    int          we0;
    int          acc0;

    n_checks    = 0;
    n_errors    = 0;
    mcu_prev    = 8'h00;
    soak_done   = 1'b0;
    mem_clr     = 1'b1;
    reset       = 1'b1;
    cpu_req     = 1'b0;
    cpu_addr    = 11'h000;
    cpu_we      = 1'b0;
    cpu_be      = 2'b00;
    cpu_din     = 16'h0000;
    mcu_cs      = 1'b0;
    mcu_we      = 1'b0;
    mcu_addr    = 12'h000;
    mcu_din     = 8'h00;
    cpu_int_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check("rst_cpu_dout", {16'h0, cpu_dout}, 32'h0);
    check("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    check("rst_mcu_dout", {24'h0, mcu_dout}, 32'h0);
    check("rst_ints", {30'h0, mcu_int, cpu_int}, 32'h0);
    check("rst_ram_port", {11'h0, ram_we, ram_wdata, ram_addr}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Word write then word read
    we0 = n_we;
    cpu_txn(11'h010, 1'b1, 2'b11, 16'hBEEF, lat, q);
    check("wr_lat", lat, 3);
    check("wr_mem_lo", {24'h0, mem[12'h020]}, 32'hEF);
    check("wr_mem_hi", {24'h0, mem[12'h021]}, 32'hBE);
    check("wr_we_count", n_we - we0, 2);
    cpu_txn(11'h010, 1'b0, 2'b11, 16'h0000, lat, q);
    check("rd_lat", lat, 4);
    check("rd_data", {16'h0, q}, 32'hBEEF);

    // Single high byte read
    acc0 = n_acc;
    cpu_txn(11'h010, 1'b0, 2'b10, 16'h0000, lat, q);
    check("rd_hi_lat", lat, 3);
    check("rd_hi_data", {16'h0, q}, 32'hBE00);
    check("rd_hi_acc", n_acc - acc0, 1);

    // Single low byte read
    cpu_txn(11'h010, 1'b0, 2'b01, 16'h0000, lat, q);
    check("rd_lo_lat", lat, 3);
    check("rd_lo_data", {16'h0, q}, 32'h00EF);

    // No byte enables: ack without touching RAM
    we0  = n_we;
    acc0 = n_acc;
    cpu_txn(11'h010, 1'b0, 2'b00, 16'h0000, lat, q);
    check("be0_lat", lat, 1);
    check("be0_data", {16'h0, q}, 32'h0000);
    check("be0_we", n_we - we0, 0);
    check("be0_acc", n_acc - acc0, 0);

    // MCU read of 0x021 strobed during LO collides with the HI slot
    fork
      cpu_txn(11'h010, 1'b0, 2'b11, 16'h0000, lat, q);
      begin
        @(negedge clk);
        mcu_rd(12'h021, 8'hBE);
      end
    join
    check("coll_lat", lat, 5);
    check("coll_data", {16'h0, q}, 32'hBEEF);

    // Mailboxes
    cpu_txn(11'h7FF, 1'b1, 2'b10, 16'h5A00, lat, q);
    check("mbx_wr_lat", lat, 2);
    check("mbx_mem_fff", {24'h0, mem[12'hFFF]}, 32'h5A);
    check("mcu_int_set", {31'h0, mcu_int}, 32'h1);
    mcu_rd(12'hFFF, 8'h5A);
    check("mcu_int_clr", {31'h0, mcu_int}, 32'h0);
    check("cpu_int_idle", {31'h0, cpu_int}, 32'h0);
    mcu_wr(12'hFFE, 8'h33, 1'b0);
    check("cpu_int_set", {31'h0, cpu_int}, 32'h1);
    check("mbx_mem_ffe", {24'h0, mem[12'hFFE]}, 32'h33);
    @(negedge clk);
    cpu_int_clr = 1'b1;
    @(posedge clk); #1;
    cpu_int_clr = 1'b0;
    check("cpu_int_clr", {31'h0, cpu_int}, 32'h0);
    mcu_wr(12'hFFE, 8'h44, 1'b1);
    check("cpu_int_set_wins", {31'h0, cpu_int}, 32'h1);

    // Soak: MCU reads every 4 clocks against back-to-back CPU word reads
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          mcu_rd(12'h020, 8'hEF);
          @(posedge clk);
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          cpu_txn(11'h010, 1'b0, 2'b11, 16'h0000, lat, q);
          check("soak_lat", {31'h0, (lat >= 1 && lat <= 6)}, 32'h1);
          check("soak_data", {16'h0, q}, 32'hBEEF);
        end
      end
    join

    // Reset during the HI slot of a word write
    cpu_txn(11'h7FF, 1'b1, 2'b10, 16'h7700, lat, q);
    mcu_wr(12'hFFE, 8'h55, 1'b0);
    check("pre_rst_ints", {30'h0, mcu_int, cpu_int}, 32'h3);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 11'h008;
    cpu_we   = 1'b1;
    cpu_be   = 2'b11;
    cpu_din  = 16'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_ack", {31'h0, cpu_ack}, 32'h0);
    check("mid_rst_ints", {30'h0, mcu_int, cpu_int}, 32'h0);
    check("mid_rst_dout", {16'h0, cpu_dout}, 32'h0);
    check("mid_rst_lo_written", {24'h0, mem[12'h010]}, 32'h34);
    check("mid_rst_hi_untouched", {24'h0, mem[12'h011]}, 32'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_ack", {31'h0, cpu_ack}, 32'h0);
    end
    cpu_txn(11'h008, 1'b0, 2'b11, 16'h0000, lat, q);
    check("post_rst_lat", lat, 4);
    check("post_rst_data", {16'h0, q}, 32'h0034);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcu_shared_ram_arb.md
# mcu_shared_ram_arb

Arbiter and sequencer for the 4 KB, 8-bit shared RAM between the main CPU (16-bit bus, req/ack handshake) and the sound MCU external-memory port (single-cycle strobes at 8 MHz cadence). It splits CPU word accesses into byte accesses on the single RAM port and gives MCU accesses fixed priority within a guaranteed latency. It also implements the two mailbox interrupts: CPU→MCU, which drives the MCU INT0 line, and MCU→CPU.

## Interface
Parameters:
- MBOX_TO_MCU, 12'hFFF, byte address whose CPU write raises `mcu_int`
- MBOX_TO_CPU, 12'hFFE, byte address whose MCU write raises `cpu_int`

Ports:
- CLK_32M  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- cpu_req  in  1  level; held until `cpu_ack`
- cpu_addr  in  11  word address (byte address bits [11:1])
- cpu_we  in  1  write when high
- cpu_be  in  2  byte enables; [0] = low byte (even address), [1] = high byte
- cpu_din  in  16  write data
- cpu_dout  out  16  read data; valid in the ack cycle, held until the next ack
- cpu_ack  out  1  one-cycle completion pulse
- mcu_cs  in  1  one-cycle access strobe, at most once per 4 clocks
- mcu_we  in  1  qualifies `mcu_cs`
- mcu_addr  in  12  byte address
- mcu_din  in  8  write data
- mcu_dout  out  8  read data; held until the next MCU read completes
- mcu_int  out  1  active-high mailbox interrupt to the MCU (inverted externally into INT0)
- cpu_int  out  1  active-high mailbox interrupt to the CPU
- cpu_int_clr  in  1  one-cycle clear of `cpu_int`
- ram_addr  out  12  RAM byte address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  8  RAM write data
- ram_q  in  8  RAM read data; synchronous, valid the cycle after the address is presented

## Operation
- Reset values: all outputs 0 and `cpu_dout` = 16'h0000. FSM is IDLE, the MCU pending flag is clear, and both interrupts are clear. RAM contents are untouched.
- Reset mid-transaction: the CPU transaction is dropped with no ack, and a pending MCU access is dropped.
- An MCU strobe is latched into a pending register (address, we, data) in the cycle after `mcu_cs`.
- Each cycle the RAM port carries at most one access.
  - A pending MCU access always wins.
  - Otherwise the current CPU byte is issued.
- FSM states:
  - IDLE: accept `cpu_req`, latch addr/we/be/din, go to LO.
  - LO: issue the low byte if `be[0]`, else skip.
  - HI: issue the high byte if `be[1]`, else skip.
  - WAIT: read data returning.
  - ACK: pulse `cpu_ack`, return to IDLE.
- A state whose byte is blocked by an MCU access holds for one cycle. A skipped byte costs no cycle. `be`=2'b00 goes IDLE→ACK with no RAM access.
- CPU read: captured bytes are assembled into `cpu_dout`. Disabled lanes return 8'h00.
- CPU write: `ram_wdata` = `cpu_din[7:0]` for the low byte, `cpu_din[15:8]` for the high byte. The byte address is {`cpu_addr`, lane}.
- Mailboxes (the data byte is still stored in RAM):
  - A CPU write of the byte at MBOX_TO_MCU sets `mcu_int`. An MCU read of MBOX_TO_MCU clears it.
  - An MCU write of MBOX_TO_CPU sets `cpu_int`. `cpu_int_clr` clears it.
  - If set and clear occur in the same cycle, set wins.
- A new `cpu_req` is not accepted in the ACK cycle. The earliest re-accept is the cycle after ACK.

## Timing
- MCU: `mcu_cs` in cycle n → RAM access in n+1 → `ram_q` in n+2 → `mcu_dout` valid from n+3. This always meets the 4-clock MCU cadence.
- MCU writes land in RAM in n+1.
- Uncontended CPU accesses (`cpu_req` seen in IDLE at cycle n):
  - word write: `cpu_ack` at n+3
  - word read: `cpu_ack` at n+4
  - single-byte read: `cpu_ack` at n+3
- Each colliding MCU access adds exactly 1 cycle. The worst-case word read is n+6.
- A CPU and an MCU access to the same byte in the same slot: the MCU access goes first, and the CPU sees the post-MCU value.

## Structure
- Package `mcu_pkg` holds:
  - the FSM state enum (IDLE, LO, HI, WAIT, ACK)
  - default mailbox address constants
  - a packed struct for the latched MCU request
- Sub-module `mcu_mailbox` holds the two set/clear interrupt flops and their address decode. Everything else stays flat.

## Test plan
- Reset, then a word write at `cpu_addr`=11'h010, `be`=2'b11, `cpu_din`=16'hBEEF → RAM[0x020]=EF, RAM[0x021]=BE, `cpu_ack` at n+3. A following word read returns 16'hBEEF with ack at n+4.
- Read with `be`=2'b10 at 11'h010 → `cpu_dout`=16'hBE00, one RAM access, ack at n+3. Transaction with `be`=2'b00 → ack with no `ram_we` and no RAM access.
- CPU word read in progress while `mcu_cs` reads 0x021 during the LO state → MCU gets BE at n+3, the CPU ack slips by exactly 1 cycle, and CPU data is correct.
- CPU writes 8'h5A to 0xFFF (word 11'h7FF, `be`=2'b10) → `mcu_int`=1. MCU read of 0xFFF returns 5A and clears `mcu_int`. MCU write 0xFFE → `cpu_int`=1. `cpu_int_clr` coincident with a new MCU write → `cpu_int` stays 1.
- Continuous MCU strobes every 4 clocks plus back-to-back CPU word reads for 1000 cycles → every MCU read meets n+3, and no CPU transaction is starved (ack ≤ n+6).
- Assert `reset` during the HI state of a CPU write → no `cpu_ack`, the high byte is not written, and the FSM is IDLE with interrupts clear on the next cycle.
